daq_frame_capture: RTL and testbench

//  Consumer stage for the DAQ read-clock generator. Gates that generator via rden_o (to its en_i).

---
 rtl/daq_frame_capture_pkg.sv | 12 +
 rtl/daq_sync_fifo.sv | 52 +++++
 rtl/daq_frame_capture.sv | 106 ++++++++++
 tb/tb_daq_frame_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/daq_frame_capture_pkg.sv
// Shared definitions for the DAQ capture path: FSM states and default bus width.
package daq_frame_capture_pkg;

  localparam int DAQ_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/daq_sync_fifo.sv
// Single-clock FIFO with same-cycle push-through-when-full and synchronous flush.
module daq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 2**AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/daq_frame_capture.sv
// Captures one NCH-sample frame from the DAQ bus on read-clock rises and
// streams the tagged samples out through a small FIFO.
module daq_frame_capture
  import daq_frame_capture_pkg::*;
#(
  parameter int DW      = DAQ_DW,
  parameter int NCH     = 8,
  parameter int FIFO_AW = 4,
  localparam int CW     = $clog2(NCH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          rdclk_i,
  output logic          rden_o,
  input  logic [DW-1:0] daq_data_i,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] chan_o,
  output logic          last_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ovf_o
);

  localparam int EW = DW + CW + 1;

  state_t            state, state_nx;
  logic [CW-1:0]     chan;
  logic              rdclk_q, rise, last_chan;
  logic              push, pop, drop;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_count;

  assign rise      = rdclk_i & ~rdclk_q;
  assign last_chan = (chan == CW'(NCH-1));
  assign push      = (state == ST_CAPTURE) && rise && !abort_i;
  assign valid_o   = (fifo_count != '0);
  assign pop       = valid_o && ready_i;
  assign drop      = push && fifo_full && !pop;

  always_comb begin
    state_nx = state;
    rden_o   = 1'b0;
    done_o   = 1'b0;
    case (state)
      ST_IDLE:    if (start_i) state_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        rden_o = 1'b1;
        if (rise && last_chan) state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty) begin
        state_nx = ST_IDLE;
        done_o   = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort_i) begin
      state_nx = ST_IDLE;
      done_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      chan    <= '0;
      rdclk_q <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      rdclk_q <= rdclk_i;
      state   <= state_nx;
      if (state == ST_IDLE && start_i && !abort_i) begin
        chan  <= '0;
        ovf_o <= 1'b0;
      end else if (push) begin
        // Channel advances even on a dropped sample so the frame still terminates.
        chan <= last_chan ? '0 : chan + 1'b1;
        if (drop) ovf_o <= 1'b1;
      end
    end
  end

  daq_sync_fifo #(
    .WIDTH (EW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .wdata   ({last_chan, chan, daq_data_i}),
    .pop     (pop),
    .flush   (abort_i),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign {last_o, chan_o, data_o} = valid_o ? fifo_rdata : '0;
  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_daq_frame_capture.sv
// Randomized scoreboard bench for daq_frame_capture with a frame-level reference model.
module tb_daq_frame_capture;

  localparam int DW      = 16;
  localparam int NCH     = 20;
  localparam int FIFO_AW = 4;
  localparam int CW      = $clog2(NCH);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int M_IDLE = 0, M_CAPTURE = 1, M_DRAIN = 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i, abort_i, rdclk_i, ready_i;
  logic [DW-1:0] daq_data_i;
  logic          rden_o, last_o, valid_o, busy_o, done_o, ovf_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] chan_o;

  daq_frame_capture #(.DW(DW), .NCH(NCH), .FIFO_AW(FIFO_AW)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .rdclk_i    (rdclk_i),
    .rden_o     (rden_o),
    .daq_data_i (daq_data_i),
    .data_o     (data_o),
    .chan_o     (chan_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          last;
    logic [CW-1:0] chan;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t hd;
  int    total = 0, bad = 0;
  int    nbeats = 0, ndone = 0;

  // Reference model: frame progress, occupancy and sticky overflow from the rules.
  int m_mode = M_IDLE, m_chan = 0, m_occ = 0;
  bit m_ovf = 0, m_prev = 0, m_rise, m_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_i or posedge reset_i);
    if (reset_i) begin
      m_mode = M_IDLE; m_chan = 0; m_occ = 0; m_ovf = 0; m_prev = 0;
      exp_q.delete();
    end else begin
      m_rise = rdclk_i && !m_prev;
      m_prev = rdclk_i;
      if (abort_i) begin
        m_mode = M_IDLE; m_occ = 0;
        exp_q.delete();
      end else begin
        m_pop = (m_occ > 0) && ready_i;
        case (m_mode)
          M_IDLE: if (start_i) begin m_mode = M_CAPTURE; m_chan = 0; m_ovf = 0; end
          M_CAPTURE: if (m_rise) begin
            if (m_occ < DEPTH || m_pop) begin
              exp_q.push_back('{last: (m_chan == NCH-1), chan: CW'(m_chan), data: daq_data_i});
              m_occ++;
            end else m_ovf = 1;
            if (m_chan == NCH-1) begin m_mode = M_DRAIN; m_chan = 0; end
            else m_chan++;
          end
          M_DRAIN: if (m_occ == 0) m_mode = M_IDLE;
          default: m_mode = M_IDLE;
        endcase
        if (m_pop) m_occ--;
      end
    end
  end

  // Monitor: compares every cycle, pops the scoreboard on each accepted beat.
  initial forever begin
    @(negedge clk_i);
    chk("valid", 64'(valid_o), 64'(m_occ != 0));
    chk("busy",  64'(busy_o),  64'(m_mode != M_IDLE));
    chk("rden",  64'(rden_o),  64'(m_mode == M_CAPTURE));
    chk("ovf",   64'(ovf_o),   64'(m_ovf));
    chk("done",  64'(done_o),  64'(m_mode == M_DRAIN && m_occ == 0 && !abort_i));
    if (done_o) ndone++;
    if (valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 64'(1), 64'(0));
      else begin
        hd = exp_q[0];
        chk("data", 64'(data_o), 64'(hd.data));
        chk("chan", 64'(chan_o), 64'(hd.chan));
        chk("last", 64'(last_o), 64'(hd.last));
        if (ready_i) begin void'(exp_q.pop_front()); nbeats++; end
      end
    end else chk("idle_head", 64'({last_o, chan_o, data_o}), 64'(0));
  end

  bit rd_run = 1, rand_ready = 0;
  int rd_cnt = 0, p_ready = 75;

  task automatic step(input bit s = 0, input bit a = 0);
    @(posedge clk_i); #2;
    start_i = s;
    abort_i = a;
    daq_data_i = DW'($urandom);
    if (rd_run) begin
      if (rd_cnt == 0) begin rdclk_i = ~rdclk_i; rd_cnt = $urandom_range(0, 2); end
      else rd_cnt--;
    end
    if (rand_ready) ready_i = ($urandom_range(0, 99) < p_ready);
  endtask

  function automatic bit cond(input int kind, input int arg);
    case (kind)
      0:       return m_mode == arg;
      1:       return m_occ == arg;
      default: return m_mode == M_CAPTURE && m_chan == arg;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int arg, input string name);
    int n = 0;
    while (!cond(kind, arg) && n < 600) begin step(); n++; end
    total++;
    if (!cond(kind, arg)) begin
      bad++;
      $display("FAIL timeout %s: condition not reached after %0d cycles", name, n);
    end
  endtask

  int b0, d0;

  initial begin
    start_i = 0; abort_i = 0; rdclk_i = 0; ready_i = 0; daq_data_i = '0;
    #1 reset_i = 1;
    repeat (3) @(posedge clk_i);
    #2 reset_i = 0;

    // Plain frame, always ready.
    ready_i = 1; b0 = nbeats; d0 = ndone;
    step(1); step();
    wait_for(0, M_IDLE, "frame_plain");
    step();
    chk("plain_beats", 64'(nbeats - b0), 64'(NCH));
    chk("plain_done",  64'(ndone - d0),  64'(1));

    // Stray start pulses during CAPTURE and DRAIN, random backpressure.
    rand_ready = 1; b0 = nbeats; d0 = ndone;
    step(1); step();
    for (int n = 0; n < 600 && m_mode != M_IDLE; n++) step($urandom_range(0, 5) == 0);
    step();
    chk("stray_start_beats", 64'(nbeats - b0), 64'(NCH));
    chk("stray_start_done",  64'(ndone - d0),  64'(1));

    // Overflow: no drain during capture, 4 samples dropped.
    rand_ready = 0; ready_i = 0; b0 = nbeats;
    step(1); step();
    wait_for(0, M_DRAIN, "ovf_fill");
    chk("ovf_sticky", 64'(ovf_o), 64'(1));
    ready_i = 1;
    wait_for(0, M_IDLE, "ovf_drain");
    step();
    chk("ovf_beats", 64'(nbeats - b0), 64'(DEPTH));
    chk("ovf_held",  64'(ovf_o), 64'(1));

    // Full FIFO with a pop and a rise in the same cycle: push must be accepted.
    ready_i = 0; b0 = nbeats;
    step(1); step();
    wait_for(1, DEPTH, "full_fill");
    rd_run = 0; rdclk_i = 0;
    step();
    ready_i = 1; rdclk_i = 1; rd_run = 1; rd_cnt = 1;
    step();
    chk("full_push_occ", 64'(valid_o), 64'(1));
    wait_for(0, M_IDLE, "full_drain");
    step();
    chk("full_push_ovf",   64'(ovf_o), 64'(0));
    chk("full_push_beats", 64'(nbeats - b0), 64'(NCH));

    // Abort after 5 rises, then a clean frame.
    rand_ready = 1; d0 = ndone;
    step(1); step();
    wait_for(2, 5, "abort_wait");
    step(0, 1);
    step();
    chk("abort_valid", 64'(valid_o), 64'(0));
    chk("abort_rden",  64'(rden_o),  64'(0));
    repeat (4) step();
    chk("abort_no_done", 64'(ndone - d0), 64'(0));
    b0 = nbeats;
    step(1); step();
    wait_for(0, M_IDLE, "post_abort");
    step();
    chk("post_abort_beats", 64'(nbeats - b0), 64'(NCH));

    // start && abort together in IDLE.
    step(1, 1); step(); step();
    chk("start_abort_idle", 64'(busy_o), 64'(0));

    // Reset mid-capture with 3 samples buffered.
    rand_ready = 0; ready_i = 0;
    step(1); step();
    wait_for(1, 3, "reset_fill");
    reset_i = 1;
    @(negedge clk_i); #1;
    chk("rst_outputs", 64'({rden_o, valid_o, busy_o, done_o, ovf_o, last_o, chan_o, data_o}), 64'(0));
    @(posedge clk_i); #2 reset_i = 0;

    // Random traffic.
    rand_ready = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) p_ready = $urandom_range(0, 100);
      step($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
